// File: rtl/reg_file_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
package reg_file_pkg;

  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int REG_DATA_WIDTH_DEF = 32;
  localparam int REG_DEPTH_DEF      = 32;
  localparam int NUM_RD_PORTS_DEF   = 2;

  typedef logic [REG_ADDR_WIDTH_DEF-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard with registered pending counter for reg_file_mp.
// Honours REG_FILE_MP_BYPASS_EN for same-cycle writeback visibility on r_busy.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_WIDTH_DEF,
  parameter int DEPTH  = REG_DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_PORTS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] r_addr [NUM_RD],
  output logic [NUM_RD-1:0] r_busy,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int SLOTS = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [SLOTS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             set_s, inc_s, dec_s;

  // Next busy vector and counter; a set wins over a clear of the same slot.
  always_comb begin
    set_s  = iss_en && (iss_rd != '0) && ({1'b0, iss_rd} < DEPTH_L);
    busy_d = busy_q;
    inc_s  = set_s && !busy_q[iss_rd];
    dec_s  = wr_en && busy_q[wr_addr] && !(set_s && (iss_rd == wr_addr));
    for (int k = 0; k < SLOTS; k++) begin
      if (set_s && (iss_rd == ADDR_W'(k))) begin
        busy_d[k] = 1'b1;
      end else if (wr_en && (wr_addr == ADDR_W'(k))) begin
        busy_d[k] = 1'b0;
      end else begin
        busy_d[k] = busy_q[k];
      end
    end
    case ({inc_s, dec_s})
      2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Per-port busy lookup; x0 and out-of-range addresses are never busy.
  always_comb begin
    r_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((r_addr[i] != '0) && ({1'b0, r_addr[i]} < DEPTH_L)) begin
        r_busy[i] = busy_q[r_addr[i]];
`ifdef REG_FILE_MP_BYPASS_EN
        if (wr_en && (wr_addr == r_addr[i])) begin
          r_busy[i] = set_s && (iss_rd == r_addr[i]);
        end else begin
          r_busy[i] = busy_q[r_addr[i]];
        end
`endif
      end else begin
        r_busy[i] = 1'b0;
      end
    end
  end

  assign pend_cnt = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired x0 and issue/writeback scoreboard.
// Optional same-cycle write-to-read bypass: define REG_FILE_MP_BYPASS_EN.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int REG_DATA_WIDTH = REG_DATA_WIDTH_DEF,
  parameter int REG_DEPTH      = REG_DEPTH_DEF,
  parameter int NUM_RD_PORTS   = NUM_RD_PORTS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      write_back_en,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [REG_DATA_WIDTH-1:0] wr_data,
  input  logic [REG_ADDR_WIDTH-1:0] r_addr [NUM_RD_PORTS],
  output logic [REG_DATA_WIDTH-1:0] r_data [NUM_RD_PORTS],
  input  logic                      iss_en,
  input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
  output logic [NUM_RD_PORTS-1:0]   r_busy,
  output logic [REG_ADDR_WIDTH:0]   pend_cnt
);

  // Storage spans the full address space so every index is exact-width;
  // slots at or above REG_DEPTH are never written and stay constant zero.
  localparam int SLOTS = 1 << REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH:0] DEPTH_L = (REG_ADDR_WIDTH+1)'(REG_DEPTH);

  logic [REG_DATA_WIDTH-1:0] mem_q [SLOTS];
  logic                      wr_eff_s;

  assign wr_eff_s = write_back_en && (wr_addr != '0) && ({1'b0, wr_addr} < DEPTH_L);

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SLOTS; k++) begin
        mem_q[k] <= '0;
      end
    end else if (wr_eff_s) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Independent combinational read muxes.
  always_comb begin
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      r_data[i] = '0;
      if ((r_addr[i] != '0) && ({1'b0, r_addr[i]} < DEPTH_L)) begin
        r_data[i] = mem_q[r_addr[i]];
`ifdef REG_FILE_MP_BYPASS_EN
        if (wr_eff_s && (wr_addr == r_addr[i])) begin
          r_data[i] = wr_data;
        end else begin
          r_data[i] = mem_q[r_addr[i]];
        end
`endif
      end else begin
        r_data[i] = '0;
      end
    end
  end

  reg_scoreboard #(
    .ADDR_W (REG_ADDR_WIDTH),
    .DEPTH  (REG_DEPTH),
    .NUM_RD (NUM_RD_PORTS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .wr_en    (wr_eff_s),
    .wr_addr  (wr_addr),
    .r_addr   (r_addr),
    .r_busy   (r_busy),
    .pend_cnt (pend_cnt)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default depth and a 16-entry instance).
module tb_reg_file_mp;

`ifdef REG_FILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        write_back_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  r_addr [2];
  logic [31:0] r_data [2];
  logic [31:0] r_data16 [2];
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic [1:0]  r_busy;
  logic [1:0]  r_busy16;
  logic [5:0]  pend_cnt;
  logic [5:0]  pend_cnt16;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_mp u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .write_back_en (write_back_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .r_addr        (r_addr),
    .r_data        (r_data),
    .iss_en        (iss_en),
    .iss_rd        (iss_rd),
    .r_busy        (r_busy),
    .pend_cnt      (pend_cnt)
  );

  reg_file_mp #(.REG_DEPTH(16)) u_dut16 (
    .clk           (clk),
    .rst_n         (rst_n),
    .write_back_en (write_back_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .r_addr        (r_addr),
    .r_data        (r_data16),
    .iss_en        (iss_en),
    .iss_rd        (iss_rd),
    .r_busy        (r_busy16),
    .pend_cnt      (pend_cnt16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ir);
    write_back_en = we;
    wr_addr       = wa;
    wr_data       = wd;
    iss_en        = ie;
    iss_rd        = ir;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    r_addr[0] = 5'd5;
    r_addr[1] = 5'd0;
    // write and issue presented during reset must be discarded
    drive(1'b1, 5'd5, 32'h0000_0BAD, 1'b1, 5'd5);
    #12;
    idle();
    #1;
    check_eq("rst_rdata0", r_data[0], 32'h0);
    check_eq("rst_busy", 32'(r_busy), 32'h0);
    check_eq("rst_pend", 32'(pend_cnt), 32'h0);

    // first effective write at the first posedge after release
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
    step();
    idle();
    check_eq("wr5_port0", r_data[0], 32'hDEAD_BEEF);
    check_eq("x0_port1", r_data[1], 32'h0);
    r_addr[0] = 5'd0;
    #1;
    check_eq("x0_port0", r_data[0], 32'h0);
    r_addr[0] = 5'd5;
    r_addr[1] = 5'd5;
    #1;
    check_eq("same_addr_p0", r_data[0], 32'hDEAD_BEEF);
    check_eq("same_addr_p1", r_data[1], 32'hDEAD_BEEF);

    // x0 write with x0 issue
    drive(1'b1, 5'd0, 32'h0000_1234, 1'b1, 5'd0);
    step();
    idle();
    r_addr[0] = 5'd0;
    r_addr[1] = 5'd0;
    #1;
    check_eq("x0wr_data", r_data[0], 32'h0);
    check_eq("x0wr_busy", 32'(r_busy), 32'h0);
    check_eq("x0wr_pend", 32'(pend_cnt), 32'h0);

    // same-cycle bypass visibility
    r_addr[1] = 5'd3;
    drive(1'b1, 5'd3, 32'h0000_00A5, 1'b0, 5'd0);
    #1;
    check_eq("byp_data", r_data[1], BYP ? 32'h0000_00A5 : 32'h0);
    step();
    idle();
    check_eq("x3_after", r_data[1], 32'h0000_00A5);

    // issue then writeback
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    step();
    idle();
    r_addr[0] = 5'd7;
    r_addr[1] = 5'd7;
    #1;
    check_eq("iss7_busy", 32'(r_busy), 32'h3);
    check_eq("iss7_pend", 32'(pend_cnt), 32'h1);
    drive(1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0);
    #1;
    check_eq("wb7_busy_now", 32'(r_busy), BYP ? 32'h0 : 32'h3);
    step();
    idle();
    check_eq("wb7_busy", 32'(r_busy), 32'h0);
    check_eq("wb7_pend", 32'(pend_cnt), 32'h0);
    check_eq("wb7_data", r_data[0], 32'h0000_0077);

    // set and clear of the same register: set wins
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    step();
    drive(1'b1, 5'd7, 32'h0000_0078, 1'b1, 5'd7);
    #1;
    check_eq("conf_busy_now", 32'(r_busy), 32'h3);
    step();
    idle();
    check_eq("conf_busy", 32'(r_busy), 32'h3);
    check_eq("conf_pend", 32'(pend_cnt), 32'h1);

    // set x9 while clearing x7: count unchanged
    drive(1'b1, 5'd7, 32'h0000_0079, 1'b1, 5'd9);
    step();
    idle();
    r_addr[1] = 5'd9;
    #1;
    check_eq("swap_busy", 32'(r_busy), 32'h2);
    check_eq("swap_pend", 32'(pend_cnt), 32'h1);
    drive(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0);
    step();
    idle();
    check_eq("x9_clear_pend", 32'(pend_cnt), 32'h0);
    check_eq("x9_data", r_data[1], 32'h0000_0099);

    // mid-operation asynchronous reset
    drive(1'b1, 5'd2, 32'h0000_0055, 1'b0, 5'd0);
    step();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(k));
      step();
    end
    idle();
    r_addr[0] = 5'd2;
    r_addr[1] = 5'd5;
    #1;
    check_eq("pre_rst_pend", 32'(pend_cnt), 32'h3);
    check_eq("pre_rst_x2", r_data[0], 32'h0000_0055);
    check_eq("pre_rst_busy", 32'(r_busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_x2", r_data[0], 32'h0);
    check_eq("mid_rst_x5", r_data[1], 32'h0);
    check_eq("mid_rst_busy", 32'(r_busy), 32'h0);
    check_eq("mid_rst_pend", 32'(pend_cnt), 32'h0);
    r_addr[0] = 5'd1;
    r_addr[1] = 5'd3;
    #1;
    check_eq("mid_rst_busy13", 32'(r_busy), 32'h0);
    #1;
    rst_n = 1'b1;

    // out-of-range write on the 16-entry instance; in range for the 32-entry one
    drive(1'b1, 5'd20, 32'h0000_CAFE, 1'b0, 5'd0);
    step();
    drive(1'b1, 5'd31, 32'h0000_1F1F, 1'b0, 5'd0);
    step();
    idle();
    r_addr[0] = 5'd20;
    r_addr[1] = 5'd4;
    #1;
    check_eq("d16_oor_data", r_data16[0], 32'h0);
    check_eq("d16_alias_data", r_data16[1], 32'h0);
    check_eq("d16_oor_busy", 32'(r_busy16), 32'h0);
    check_eq("d16_pend", 32'(pend_cnt16), 32'h0);
    check_eq("d32_x20", r_data[0], 32'h0000_CAFE);
    r_addr[1] = 5'd31;
    #1;
    check_eq("d32_x31", r_data[1], 32'h0000_1F1F);
    check_eq("d16_x31", r_data16[1], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
